// File: rtl/eth_helper_scheduler_pkg.sv
// eth_helper_pkg: shared state encoding, keep constant and header widths for the helper scheduler
package eth_helper_pkg;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;
  localparam logic [7:0] KEEP_FULL = 8'hFF;
  localparam int DA_W = 48;
  localparam int LT_W = 16;
  localparam int SW_W = 16;
endpackage

// File: rtl/eth_helper_scheduler_if.sv
// eth_helper_scheduler_if: requester streams, helper stream, helper snoop and header config
interface eth_helper_scheduler_if
  import eth_helper_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DATA_WIDTH = 64
);
  logic [NUM_SRC*DATA_WIDTH-1:0] S_AXIS_tdata;
  logic [NUM_SRC*8-1:0] S_AXIS_tkeep;
  logic [NUM_SRC-1:0] S_AXIS_tvalid;
  logic [NUM_SRC-1:0] S_AXIS_tready;
  logic [NUM_SRC*DA_W-1:0] Src_Destination_Address;
  logic [NUM_SRC*LT_W-1:0] Src_Link_Type;
  logic [NUM_SRC*SW_W-1:0] Src_SyncWord;
  logic [DATA_WIDTH-1:0] H_AXIS_tdata;
  logic [7:0] H_AXIS_tkeep;
  logic H_AXIS_tvalid;
  logic H_AXIS_tready;
  logic [DA_W-1:0] Destination_Address;
  logic [LT_W-1:0] Link_Type;
  logic [SW_W-1:0] SyncWord;
  logic HM_tvalid;
  logic HM_tready;
  logic HM_tlast;
  modport slave (
    input S_AXIS_tdata, S_AXIS_tkeep, S_AXIS_tvalid, Src_Destination_Address, Src_Link_Type,
          Src_SyncWord, H_AXIS_tready, HM_tvalid, HM_tready, HM_tlast,
    output S_AXIS_tready, H_AXIS_tdata, H_AXIS_tkeep, H_AXIS_tvalid, Destination_Address,
           Link_Type, SyncWord
  );
  modport master (
    output S_AXIS_tdata, S_AXIS_tkeep, S_AXIS_tvalid, Src_Destination_Address, Src_Link_Type,
           Src_SyncWord, H_AXIS_tready, HM_tvalid, HM_tready, HM_tlast,
    input S_AXIS_tready, H_AXIS_tdata, H_AXIS_tkeep, H_AXIS_tvalid, Destination_Address,
          Link_Type, SyncWord
  );
endinterface

// File: rtl/eth_helper_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first requester at or after ptr
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic [N-1:0] gnt,
  output logic [1:0]   idx
);
  localparam logic [N-1:0] ONE = 1;
  logic [N-1:0] rot_n;
  logic [3:0] rot;
  logic [1:0] off;
  logic [2:0] sum;
  always_comb begin
    rot_n = (req >> ptr) | (req << (3'(N) - {1'b0, ptr}));
    rot = '0;
    rot[N-1:0] = rot_n;
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    sum = {1'b0, ptr} + {1'b0, off};
    idx = sum >= 3'(N) ? 2'(sum - 3'(N)) : sum[1:0];
    gnt = |req ? ONE << idx : '0;
  end
endmodule

// File: rtl/eth_helper_scheduler.sv
// eth_helper_scheduler: round-robin feeder of AXIS requesters into an Ethernet helper
module eth_helper_scheduler
  import eth_helper_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DATA_WIDTH = 64,
  parameter int BEATS_PER_PKT = 8,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  eth_helper_scheduler_if.slave bus,
  output logic [1:0]            grant_idx,
  output logic [31:0]           pkt_count,
  output logic                  timeout_err,
  output logic                  busy
);
  localparam logic [NUM_SRC-1:0] ONE = 1;
  state_t state, state_d;
  logic [1:0] rr_ptr, arb_idx, next_ptr;
  logic [NUM_SRC-1:0] arb_gnt;
  logic [31:0] beat_cnt, drain_cnt;
  logic [DATA_WIDTH-1:0] td [4];
  logic [7:0] tk [4];
  logic tv [4];
  logic [DA_W-1:0] da [4];
  logic [LT_W-1:0] lt [4];
  logic [SW_W-1:0] sw [4];
  logic hs, last_beat, tlast_seen, timed_out;
  for (genvar g = 0; g < 4; g++) begin : g_src
    if (g < NUM_SRC) begin : g_on
      assign td[g] = bus.S_AXIS_tdata[g*DATA_WIDTH +: DATA_WIDTH];
      assign tk[g] = bus.S_AXIS_tkeep[g*8 +: 8];
      assign tv[g] = bus.S_AXIS_tvalid[g];
      assign da[g] = bus.Src_Destination_Address[g*DA_W +: DA_W];
      assign lt[g] = bus.Src_Link_Type[g*LT_W +: LT_W];
      assign sw[g] = bus.Src_SyncWord[g*SW_W +: SW_W];
    end else begin : g_off
      assign td[g] = '0;
      assign tk[g] = '0;
      assign tv[g] = 1'b0;
      assign da[g] = '0;
      assign lt[g] = '0;
      assign sw[g] = '0;
    end
  end
  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .req(bus.S_AXIS_tvalid),
    .ptr(rr_ptr),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );
  assign bus.H_AXIS_tvalid = state == FEED && tv[grant_idx];
  assign bus.H_AXIS_tdata = state == FEED ? td[grant_idx] : '0;
  assign bus.H_AXIS_tkeep = state == FEED ? tk[grant_idx] : '0;
  assign bus.S_AXIS_tready = (state == FEED && bus.H_AXIS_tready) ? ONE << grant_idx : '0;
  assign hs = bus.H_AXIS_tvalid && bus.H_AXIS_tready;
  assign last_beat = hs && (beat_cnt == 32'(BEATS_PER_PKT - 1) || bus.H_AXIS_tkeep != KEEP_FULL);
  assign tlast_seen = bus.HM_tvalid && bus.HM_tready && bus.HM_tlast;
  assign timed_out = drain_cnt == 32'(DRAIN_TIMEOUT - 1);
  assign next_ptr = grant_idx == 2'(NUM_SRC - 1) ? 2'd0 : grant_idx + 2'd1;
  assign busy = state != IDLE;
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = |arb_gnt ? FEED : IDLE;
      FEED: state_d = last_beat ? DRAIN : FEED;
      default: state_d = (tlast_seen || timed_out) ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_idx <= '0;
      beat_cnt <= '0;
      drain_cnt <= '0;
      pkt_count <= '0;
      timeout_err <= 1'b0;
      bus.Destination_Address <= '0;
      bus.Link_Type <= '0;
      bus.SyncWord <= '0;
    end else begin
      state <= state_d;
      beat_cnt <= state == IDLE ? '0 : beat_cnt + 32'(hs);
      drain_cnt <= state == DRAIN ? drain_cnt + 32'd1 : '0;
      if (state == IDLE && |arb_gnt) begin
        grant_idx <= arb_idx;
        bus.Destination_Address <= da[arb_idx];
        bus.Link_Type <= lt[arb_idx];
        bus.SyncWord <= sw[arb_idx];
      end
      if (state == DRAIN && (tlast_seen || timed_out)) rr_ptr <= next_ptr;
      if (state == DRAIN && tlast_seen) pkt_count <= pkt_count + 32'd1;
      if (state == DRAIN && !tlast_seen && timed_out) timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_eth_helper_scheduler.sv
// tb_eth_helper_scheduler: directed scenarios for the helper scheduler with hand-derived expectations
module tb_eth_helper_scheduler;
  localparam logic [47:0] SDA0 = 48'h0000_AABB_CC00;
  localparam logic [47:0] SDA1 = 48'h1111_2233_4455;
  localparam logic [15:0] SLT0 = 16'h0800;
  localparam logic [15:0] SLT1 = 16'h86DD;
  localparam logic [15:0] SSW0 = 16'hA5A5;
  localparam logic [15:0] SSW1 = 16'h5A5A;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic [1:0] grant_idx;
  logic [31:0] pkt_count;
  logic timeout_err, busy;
  logic [63:0] lane_data [2];
  logic [7:0] lane_keep [2];
  logic [1:0] lane_valid;
  int checks = 0;
  int errors = 0;
  eth_helper_scheduler_if #(.NUM_SRC(2), .DATA_WIDTH(64)) bus ();
  eth_helper_scheduler #(
    .NUM_SRC(2),
    .DATA_WIDTH(64),
    .BEATS_PER_PKT(8),
    .DRAIN_TIMEOUT(1024)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .bus(bus),
    .grant_idx(grant_idx),
    .pkt_count(pkt_count),
    .timeout_err(timeout_err),
    .busy(busy)
  );
  always #5 ACLK = ~ACLK;
  assign bus.S_AXIS_tdata = {lane_data[1], lane_data[0]};
  assign bus.S_AXIS_tkeep = {lane_keep[1], lane_keep[0]};
  assign bus.S_AXIS_tvalid = lane_valid;
  assign bus.Src_Destination_Address = {SDA1, SDA0};
  assign bus.Src_Link_Type = {SLT1, SLT0};
  assign bus.Src_SyncWord = {SSW1, SSW0};

  function automatic logic [63:0] beat_data(input logic s, input int b);
    return {8'hD0, 7'd0, s, 24'd0, 24'(b)};
  endfunction

  task automatic set_hm(input logic v);
    bus.HM_tvalid = v;
    bus.HM_tready = v;
    bus.HM_tlast = v;
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1;
    lane_valid = '0;
    bus.H_AXIS_tready = 1'b1;
    set_hm(1'b0);
    @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  task automatic send_pkt(input logic s, input int n, input logic [7:0] last_keep,
                          input int stall_at, input int stall_len,
                          output int hs, output int bad, output int rdy,
                          output int stalls, output int hdr_bad);
    int b, left, cyc;
    logic [7:0] k;
    b = 0; left = stall_len; cyc = 0;
    hs = 0; bad = 0; rdy = 0; stalls = 0; hdr_bad = 0;
    while (b < n && cyc < 200) begin
      @(negedge ACLK);
      k = (b == n - 1) ? last_keep : 8'hFF;
      lane_valid[s] = 1'b1;
      lane_data[s] = beat_data(s, b);
      lane_keep[s] = k;
      bus.H_AXIS_tready = !(b == stall_at && left > 0);
      #1;
      if (!bus.H_AXIS_tready) begin
        left--;
        if (bus.H_AXIS_tvalid) stalls++;
      end
      if (bus.S_AXIS_tready[s]) rdy++;
      if (busy && (bus.Destination_Address !== (s ? SDA1 : SDA0) ||
                   bus.Link_Type !== (s ? SLT1 : SLT0) || bus.SyncWord !== (s ? SSW1 : SSW0)))
        hdr_bad++;
      if (bus.H_AXIS_tvalid && bus.H_AXIS_tready) begin
        if (bus.H_AXIS_tdata !== beat_data(s, b) || bus.H_AXIS_tkeep !== k) bad++;
        hs++;
        b++;
      end
      cyc++;
    end
  endtask

  task automatic finish_pkt(input int delay);
    repeat (delay) @(negedge ACLK);
    @(negedge ACLK);
    set_hm(1'b1);
    @(negedge ACLK);
    set_hm(1'b0);
    #1;
  endtask

  task automatic test_reset();
    lane_valid = 2'b11;
    @(negedge ACLK);
    @(negedge ACLK);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant_idx); end
    checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %0b expected 0", timeout_err); end
    checks++; if (bus.S_AXIS_tready !== 2'b00) begin errors++; $display("FAIL reset_tready: got %b expected 00", bus.S_AXIS_tready); end
    checks++; if (bus.H_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL reset_h_tvalid: got %0b expected 0", bus.H_AXIS_tvalid); end
    checks++; if ({bus.Destination_Address, bus.Link_Type, bus.SyncWord} !== 80'd0) begin
      errors++; $display("FAIL reset_header: got %h expected 0", {bus.Destination_Address, bus.Link_Type, bus.SyncWord});
    end
    lane_valid = '0;
    ARESET = 1'b0;
  endtask

  task automatic test_single_pkt();
    int hs, bad, rdy, st, hb;
    do_reset();
    send_pkt(1'b0, 8, 8'hFF, -1, 0, hs, bad, rdy, st, hb);
    @(negedge ACLK);
    lane_valid = '0;
    #1;
    checks++; if (hs !== 8) begin errors++; $display("FAIL single_beats: got %0d expected 8", hs); end
    checks++; if (rdy !== 8) begin errors++; $display("FAIL single_tready_cycles: got %0d expected 8", rdy); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL single_data: got %0d bad beats expected 0", bad); end
    checks++; if (hb !== 0) begin errors++; $display("FAIL single_header: got %0d bad cycles expected 0", hb); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL single_grant: got %0d expected 0", grant_idx); end
    checks++; if (bus.Destination_Address !== SDA0) begin errors++; $display("FAIL single_drain_da: got %h expected %h", bus.Destination_Address, SDA0); end
    finish_pkt(2);
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL single_pkt_count: got %0d expected 1", pkt_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %0b expected 0", busy); end
  endtask

  task automatic test_alternate();
    int hs, bad, rdy, st, hb;
    do_reset();
    lane_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      send_pkt(1'(i), 8, 8'hFF, -1, 0, hs, bad, rdy, st, hb);
      checks++; if (grant_idx !== 2'(i % 2)) begin errors++; $display("FAIL alt_grant%0d: got %0d expected %0d", i, grant_idx, i % 2); end
      checks++; if (hs !== 8 || bad !== 0) begin errors++; $display("FAIL alt_beats%0d: got %0d beats %0d bad expected 8 beats 0 bad", i, hs, bad); end
      finish_pkt(1);
    end
    lane_valid = '0;
    checks++; if (pkt_count !== 32'd4) begin errors++; $display("FAIL alt_pkt_count: got %0d expected 4", pkt_count); end
  endtask

  task automatic test_short_keep();
    int hs, bad, rdy, st, hb;
    do_reset();
    send_pkt(1'b1, 3, 8'h0F, -1, 0, hs, bad, rdy, st, hb);
    checks++; if (hs !== 3 || bad !== 0) begin errors++; $display("FAIL short_beats: got %0d beats %0d bad expected 3 beats 0 bad", hs, bad); end
    @(negedge ACLK);
    #1;
    checks++; if (bus.S_AXIS_tready[1] !== 1'b0) begin errors++; $display("FAIL short_tready_cycle4: got %0b expected 0", bus.S_AXIS_tready[1]); end
    checks++; if (busy !== 1'b1 || bus.H_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL short_drain: got busy %0b h_tvalid %0b expected 1 0", busy, bus.H_AXIS_tvalid); end
    lane_valid = '0;
    finish_pkt(0);
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL short_pkt_count: got %0d expected 1", pkt_count); end
  endtask

  task automatic test_timeout();
    int hs, bad, rdy, st, hb, cnt;
    do_reset();
    send_pkt(1'b0, 8, 8'hFF, -1, 0, hs, bad, rdy, st, hb);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early_err: got %0b expected 0", timeout_err); end
    cnt = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge ACLK);
      lane_valid = 2'b11;
      #1;
      if (!busy) break;
      cnt++;
    end
    checks++; if (cnt !== 1024) begin errors++; $display("FAIL to_drain_cycles: got %0d expected 1024", cnt); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err: got %0b expected 1", timeout_err); end
    checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL to_pkt_count: got %0d expected 0", pkt_count); end
    @(negedge ACLK);
    #1;
    checks++; if (busy !== 1'b1 || grant_idx !== 2'd1) begin errors++; $display("FAIL to_next_grant: got busy %0b grant %0d expected 1 1", busy, grant_idx); end
    lane_valid = '0;
  endtask

  task automatic test_reset_mid_feed();
    int hs, bad, rdy, st, hb;
    do_reset();
    send_pkt(1'b0, 8, 8'hFF, -1, 0, hs, bad, rdy, st, hb);
    @(negedge ACLK);
    lane_valid = '0;
    finish_pkt(0);
    lane_valid = 2'b10;
    send_pkt(1'b1, 3, 8'hFF, -1, 0, hs, bad, rdy, st, hb);
    checks++; if (grant_idx !== 2'd1 || hs !== 3) begin errors++; $display("FAIL rst_pre: got grant %0d beats %0d expected 1 3", grant_idx, hs); end
    @(negedge ACLK);
    ARESET = 1'b1;
    lane_valid = '0;
    @(negedge ACLK);
    #1;
    checks++; if (busy !== 1'b0 || bus.S_AXIS_tready !== 2'b00 || bus.H_AXIS_tvalid !== 1'b0) begin
      errors++; $display("FAIL rst_outputs: got busy %0b tready %b h_tvalid %0b expected 0 00 0", busy, bus.S_AXIS_tready, bus.H_AXIS_tvalid);
    end
    checks++; if ({bus.Destination_Address, bus.Link_Type, bus.SyncWord} !== 80'd0) begin
      errors++; $display("FAIL rst_header: got %h expected 0", {bus.Destination_Address, bus.Link_Type, bus.SyncWord});
    end
    checks++; if (pkt_count !== 32'd0 || grant_idx !== 2'd0) begin errors++; $display("FAIL rst_status: got pkt %0d grant %0d expected 0 0", pkt_count, grant_idx); end
    ARESET = 1'b0;
    lane_valid = 2'b11;
    @(negedge ACLK);
    #1;
    checks++; if (busy !== 1'b1 || grant_idx !== 2'd0) begin errors++; $display("FAIL rst_next_grant: got busy %0b grant %0d expected 1 0", busy, grant_idx); end
    lane_valid = '0;
  endtask

  task automatic test_backpressure();
    int hs, bad, rdy, st, hb;
    do_reset();
    send_pkt(1'b0, 8, 8'hFF, 2, 5, hs, bad, rdy, st, hb);
    checks++; if (hs !== 8) begin errors++; $display("FAIL bp_beats: got %0d expected 8", hs); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_data: got %0d bad beats expected 0", bad); end
    checks++; if (st !== 5) begin errors++; $display("FAIL bp_stall_cycles: got %0d expected 5", st); end
    checks++; if (rdy !== 8) begin errors++; $display("FAIL bp_tready_cycles: got %0d expected 8", rdy); end
    @(negedge ACLK);
    lane_valid = '0;
    finish_pkt(0);
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL bp_pkt_count: got %0d expected 1", pkt_count); end
  endtask

  task automatic test_tlast_ignored();
    int hs, bad, rdy, st, hb;
    do_reset();
    set_hm(1'b1);
    repeat (3) @(negedge ACLK);
    #1;
    checks++; if (pkt_count !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL tl_idle: got pkt %0d busy %0b expected 0 0", pkt_count, busy); end
    send_pkt(1'b0, 8, 8'hFF, -1, 0, hs, bad, rdy, st, hb);
    checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL tl_feed: got %0d expected 0", pkt_count); end
    @(negedge ACLK);
    lane_valid = '0;
    @(negedge ACLK);
    set_hm(1'b0);
    #1;
    checks++; if (pkt_count !== 32'd1 || busy !== 1'b0) begin errors++; $display("FAIL tl_drain: got pkt %0d busy %0b expected 1 0", pkt_count, busy); end
  endtask

  initial begin
    lane_valid = '0;
    lane_data = '{default: '0};
    lane_keep = '{default: 8'hFF};
    bus.H_AXIS_tready = 1'b1;
    set_hm(1'b0);
    test_reset();
    test_single_pkt();
    test_alternate();
    test_short_keep();
    test_timeout();
    test_reset_mid_feed();
    test_backpressure();
    test_tlast_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
